// File: rtl/reg_share_arb_pkg.sv
// Shared definitions for the round-robin register-sharing arbiter.
package reg_share_arb_pkg;

    localparam int unsigned DefN     = 4;
    localparam int unsigned DefWidth = 8;

    // StLocked is only reachable when the lock feature is compiled in.
    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StLocked
    } arb_state_e;

    // Ceiling log2 with a floor of 1, so a 2-requester index still has one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set req scanning from ptr upward, wrapping mod N.
module reg_share_arbiter_rr_pick
    import reg_share_arb_pkg::*;
#(
    parameter int unsigned N    = DefN,
    parameter int unsigned IdxW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            any
);

    // Walk the N candidates in priority order and keep the first requester.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            logic [IdxW:0] s;
            s = {1'b0, ptr} + (IdxW + 1)'(k);
            if (s >= (IdxW + 1)'(N)) begin
                s = s - (IdxW + 1)'(N);
            end
            if (!any && req[s[IdxW-1:0]]) begin
                any               = 1'b1;
                gnt[s[IdxW-1:0]]  = 1'b1;
                idx               = s[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N requesters.
// Optional owner lock: define REG_SHARE_ARB_LOCK_EN to add the lock port and LOCKED state.
module reg_share_arbiter
    import reg_share_arb_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned GAP   = 0,
    localparam int unsigned IdxW = clog2(N)
) (
    input  logic              c,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [N*WIDTH-1:0] wdata,
`ifdef REG_SHARE_ARB_LOCK_EN
    input  logic [N-1:0]      lock,
`endif
    output logic [N-1:0]      gnt,
    output logic [WIDTH-1:0]  q,
    output logic [IdxW-1:0]   owner,
    output logic              wr_valid
);

    arb_state_e       state_q, state_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] q_q;
    logic [IdxW-1:0]  owner_q;
    logic             wr_valid_q;

    logic [N-1:0]     pick_gnt;
    logic [IdxW-1:0]  pick_idx;
    logic             pick_any;
    logic             wr;
    logic [IdxW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_data;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (i == IdxW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    reg_share_arbiter_rr_pick #(
        .N    (N),
        .IdxW (IdxW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state, grant and write-select decode; grant is forced low while in reset.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gap_cnt_d = gap_cnt_q;
        gnt       = '0;
        wr        = 1'b0;
        wr_idx    = pick_idx;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt   = pick_gnt;
                    wr    = 1'b1;
                    ptr_d = next_idx(pick_idx);
`ifdef REG_SHARE_ARB_LOCK_EN
                    if (lock[pick_idx]) begin
                        state_d = StLocked;
                        ptr_d   = ptr_q;
                    end else
`endif
                    if (GAP > 0) begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                    end
                end
            end
            StGap: begin
                if (32'(gap_cnt_q) + 32'd1 >= GAP) begin
                    state_d   = StIdle;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            StLocked: begin
`ifdef REG_SHARE_ARB_LOCK_EN
                if (req[owner_q] && lock[owner_q]) begin
                    gnt[owner_q] = 1'b1;
                    wr           = 1'b1;
                    wr_idx       = owner_q;
                end else begin
                    ptr_d = next_idx(owner_q);
                    if (GAP > 0) begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
        if (!rst) begin
            gnt = '0;
        end
    end

    // Select the winner's data slice; wdata never feeds the grant path.
    always_comb begin
        wr_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (wr_idx == IdxW'(i)) begin
                wr_data = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // State, pointer and shared register; reset discards any write pending at that edge.
    always_ff @(posedge c) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            gap_cnt_q  <= '0;
            q_q        <= '0;
            owner_q    <= '0;
            wr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gap_cnt_q  <= gap_cnt_d;
            wr_valid_q <= wr;
            if (wr) begin
                q_q     <= wr_data;
                owner_q <= wr_idx;
            end
        end
    end

    assign q        = q_q;
    assign owner    = owner_q;
    assign wr_valid = wr_valid_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench: dut0 with GAP=0 (rotation, wrap, reset), dut1 with GAP=2 (idle gaps).
// With REG_SHARE_ARB_LOCK_EN defined, also exercises the lock path on dut0.
module tb_reg_share_arbiter;

    typedef struct {
        logic [7:0] d;
        logic [1:0] o;
    } exp_t;

    logic        c = 1'b0;
    logic        rst;
    logic [3:0]  req0, req1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  gnt0, gnt1;
    logic [7:0]  q0, q1;
    logic [1:0]  owner0, owner1;
    logic        wr_valid0, wr_valid1;
`ifdef REG_SHARE_ARB_LOCK_EN
    logic [3:0]  lock0, lock1;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    int   mptr = 0;

    always #5 c = ~c;

    reg_share_arbiter #(.N(4), .WIDTH(8), .GAP(0)) dut0 (
        .c        (c),
        .rst      (rst),
        .req      (req0),
        .wdata    (wdata0),
`ifdef REG_SHARE_ARB_LOCK_EN
        .lock     (lock0),
`endif
        .gnt      (gnt0),
        .q        (q0),
        .owner    (owner0),
        .wr_valid (wr_valid0)
    );

    reg_share_arbiter #(.N(4), .WIDTH(8), .GAP(2)) dut1 (
        .c        (c),
        .rst      (rst),
        .req      (req1),
        .wdata    (wdata1),
`ifdef REG_SHARE_ARB_LOCK_EN
        .lock     (lock1),
`endif
        .gnt      (gnt1),
        .q        (q1),
        .owner    (owner1),
        .wr_valid (wr_valid1)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One dut0 cycle: predict grant from the model pointer, push the expected write,
    // then after the edge check wr_valid and pop the scoreboard.
    task automatic cycle0(input logic [3:0] r, input logic [31:0] d, input logic rs);
        logic [3:0] eg;
        bit         found;
        exp_t       e;
        int         j;
        req0   = r;
        wdata0 = d;
        rst    = rs;
        eg     = '0;
        found  = 0;
        #1;
        if (rs) begin
            for (int k = 0; k < 4; k++) begin
                j = (mptr + k) % 4;
                if (!found && r[j]) begin
                    found = 1;
                    eg[j] = 1'b1;
                    e.d   = d[j*8 +: 8];
                    e.o   = 2'(j);
                end
            end
        end
        check_eq("gnt0", 32'(gnt0), 32'(eg));
        if (found) begin
            sb0.push_back(e);
            mptr = (int'(e.o) + 1) % 4;
        end
        @(posedge c);
        #1;
        check_eq("wr_valid0", 32'(wr_valid0), 32'(found));
        if (found) begin
            e = sb0.pop_front();
            check_eq("q0", 32'(q0), 32'(e.d));
            check_eq("owner0", 32'(owner0), 32'(e.o));
        end
        if (!rs) begin
            mptr = 0;
            check_eq("q0_rst", 32'(q0), 32'h0);
            check_eq("owner0_rst", 32'(owner0), 32'h0);
        end
    endtask

    initial begin
        exp_t e;
        logic [31:0] dat;
        bit wrote;
        rst    = 1'b0;
        req0   = 4'b1111;
        req1   = 4'b0000;
        wdata0 = 32'h44332211;
        wdata1 = '0;
`ifdef REG_SHARE_ARB_LOCK_EN
        lock0  = '0;
        lock1  = '0;
`endif
        @(posedge c);
        @(posedge c);
        #1;
        check_eq("rst_q", 32'(q0), 32'h0);
        check_eq("rst_owner", 32'(owner0), 32'h0);
        check_eq("rst_wr_valid", 32'(wr_valid0), 32'h0);
        check_eq("rst_gnt", 32'(gnt0), 32'h0);

        // Rotation: 11,22,33,44,11.
        dat = 32'h44332211;
        for (int i = 0; i < 5; i++) cycle0(4'b1111, dat, 1'b1);

        // Skip and wrap: ptr 1 -> winner 2 (ptr 3) -> winner 1 (ptr 2) -> winner 3 (ptr 0).
        cycle0(4'b0100, dat, 1'b1);
        cycle0(4'b0010, dat, 1'b1);
        cycle0(4'b1000, dat, 1'b1);
        cycle0(4'b0000, dat, 1'b1);
        cycle0(4'b1111, dat, 1'b1);

        // Mid-op reset: move ptr to 2, then reset on the edge that would grant 2.
        cycle0(4'b0010, dat, 1'b1);
        cycle0(4'b0100, 32'h0000A500, 1'b0);
        cycle0(4'b1010, 32'h66007700, 1'b1);

        // GAP=2 on dut1: writes on edges 1, 4, 7.
        req0 = '0;
        for (int k = 0; k < 9; k++) begin
            req1   = 4'b0001;
            wdata1 = {24'h0, 8'(8'h10 + k)};
            wrote  = (k % 3 == 0);
            #1;
            check_eq("gnt1", 32'(gnt1), wrote ? 32'h1 : 32'h0);
            if (wrote) begin
                e.d = 8'(8'h10 + k);
                e.o = 2'd0;
                sb1.push_back(e);
            end
            @(posedge c);
            #1;
            check_eq("wr_valid1", 32'(wr_valid1), 32'(wrote));
            if (wrote) begin
                e = sb1.pop_front();
                check_eq("q1", 32'(q1), 32'(e.d));
                check_eq("owner1", 32'(owner1), 32'(e.o));
            end
        end
        req1 = '0;

`ifdef REG_SHARE_ARB_LOCK_EN
        rst = 1'b0;
        @(posedge c);
        #1;
        rst   = 1'b1;
        req0  = 4'b0110;
        lock0 = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("lock_gnt", 32'(gnt0), 32'h2);
            @(posedge c);
            #1;
        end
        lock0 = '0;
        #1;
        check_eq("lock_exit_gnt", 32'(gnt0), 32'h0);
        @(posedge c);
        #1;
        check_eq("post_lock_gnt", 32'(gnt0), 32'h4);
        @(posedge c);
        #1;
        req0 = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
